// File: rtl/hcmpp_ram.sv
`default_nettype none
// ============================================================================
// Module  : hcmpp_ram
// Purpose : Synchronous true dual-port RAM holding the hit-count-map (HCM)
//           rows for the HCM pattern-processing path.  Port A is the
//           controller's write-back port, port B its lookup port.  Both
//           ports share clk, are read-first, and port A wins when both
//           ports write the same row in the same cycle.
// Ports   : clk            - clock, rising edge
//           reset          - synchronous active-high; clears output
//                            registers only, memory rows are untouched
//           ena/wea        - port A enable / write enable
//           addra/dina     - port A row address / write data
//           douta          - port A read data
//           enb/web        - port B enable / write enable
//           addrb/dinb     - port B row address / write data
//           doutb          - port B read data
// Options : HCMPP_RAM_OUTPUT_REG_EN - when defined, adds one output register
//           stage per port (read latency 2 instead of 1).
// Revision: 1.0 - initial release
// ============================================================================
module hcmpp_ram #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ena,
    input  logic                  wea,
    input  logic [ADDR_WIDTH-1:0] addra,
    input  logic [DATA_WIDTH-1:0] dina,
    output logic [DATA_WIDTH-1:0] douta,
    input  logic                  enb,
    input  logic                  web,
    input  logic [ADDR_WIDTH-1:0] addrb,
    input  logic [DATA_WIDTH-1:0] dinb,
    output logic [DATA_WIDTH-1:0] doutb
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // Rows power up as zero.
    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1] = '{default: '0};

    logic                  write_a;
    logic                  write_b;
    logic [DATA_WIDTH-1:0] rd_a;
    logic [DATA_WIDTH-1:0] rd_b;

    // Writes are suppressed while reset is high.  Port B's write is dropped
    // when port A writes the same row, so port A always wins a collision.
    // The address compare only matters when both writes are enabled, so an
    // X address on a disabled port cannot leak into the result.
    assign write_a = ena & wea & ~reset;
    assign write_b = enb & web & ~reset & ~(write_a && (addra == addrb));

    always_ff @(posedge clk) begin
        if (write_a) begin
            mem[addra] <= dina;
        end
        if (write_b) begin
            mem[addrb] <= dinb;
        end
    end

    // Read-first: the array read sees the contents before this edge's write.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_a <= '0;
        end else if (ena) begin
            rd_a <= mem[addra];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_b <= '0;
        end else if (enb) begin
            rd_b <= mem[addrb];
        end
    end

`ifdef HCMPP_RAM_OUTPUT_REG_EN
    // Extra output stage; each advances only with its own port enable.
    logic [DATA_WIDTH-1:0] out_a;
    logic [DATA_WIDTH-1:0] out_b;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_a <= '0;
        end else if (ena) begin
            out_a <= rd_a;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_b <= '0;
        end else if (enb) begin
            out_b <= rd_b;
        end
    end

    assign douta = out_a;
    assign doutb = out_b;
`else
    assign douta = rd_a;
    assign doutb = rd_b;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hcmpp_ram.sv
`default_nettype none
// ============================================================================
// Module  : tb_hcmpp_ram
// Purpose : Directed self-checking bench for hcmpp_ram.  Expected values are
//           hand-computed constants; read latency follows the
//           HCMPP_RAM_OUTPUT_REG_EN build option.
// Revision: 1.0 - initial release
// ============================================================================
module tb_hcmpp_ram;

`ifdef HCMPP_RAM_OUTPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk;
    logic        reset;
    logic        ena;
    logic        wea;
    logic [9:0]  addra;
    logic [15:0] dina;
    logic [15:0] douta;
    logic        enb;
    logic        web;
    logic [9:0]  addrb;
    logic [15:0] dinb;
    logic [15:0] doutb;

    int errors = 0;
    int checks = 0;

    hcmpp_ram #(
        .ADDR_WIDTH(10),
        .DATA_WIDTH(16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .ena   (ena),
        .wea   (wea),
        .addra (addra),
        .dina  (dina),
        .douta (douta),
        .enb   (enb),
        .web   (web),
        .addrb (addrb),
        .dinb  (dinb),
        .doutb (doutb)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one edge and settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        ena = 1'b0; wea = 1'b0; enb = 1'b0; web = 1'b0;
    endtask

    // Read a row through port B, holding enb for the full latency.
    task automatic read_b(input logic [9:0] addr, input string tag, input logic [15:0] exp);
        idle();
        enb = 1'b1; addrb = addr;
        repeat (LAT) tick();
        check(tag, doutb, exp);
        enb = 1'b0;
    endtask

    task automatic read_a(input logic [9:0] addr, input string tag, input logic [15:0] exp);
        idle();
        ena = 1'b1; addra = addr;
        repeat (LAT) tick();
        check(tag, douta, exp);
        ena = 1'b0;
    endtask

    task automatic write_a(input logic [9:0] addr, input logic [15:0] data);
        idle();
        ena = 1'b1; wea = 1'b1; addra = addr; dina = data;
        tick();
        idle();
    endtask

    initial begin
        reset = 1'b1;
        idle();
        addra = '0; addrb = '0; dina = '0; dinb = '0;

        // Reset held for two cycles; outputs must be zero.
        tick();
        check("reset_douta_c1", douta, 16'h0000);
        check("reset_doutb_c1", doutb, 16'h0000);
        tick();
        check("reset_douta_c2", douta, 16'h0000);
        reset = 1'b0;

        read_b(10'h005, "init_read_005", 16'h0000);

        // Write 0x0123 to 0x00A; the writing port sees the old (zero) value.
        idle();
        ena = 1'b1; wea = 1'b1; addra = 10'h00A; dina = 16'h0123;
        repeat (LAT) tick();
        check("a_read_first", douta, 16'h0000);
        idle();
        read_b(10'h00A, "write_then_read", 16'h0123);

        // Cross-port collision: A writes while B reads the same row.
        write_a(10'h010, 16'h0001);
        ena = 1'b1; wea = 1'b1; addra = 10'h010; dina = 16'h0BEE;
        enb = 1'b1; addrb = 10'h010;
        tick();
        ena = 1'b0; wea = 1'b0;
        repeat (LAT - 1) tick();
        check("collision_old", doutb, 16'h0001);
        read_b(10'h010, "collision_new", 16'h0BEE);

        // Both ports write the same row: port A wins.
        idle();
        ena = 1'b1; wea = 1'b1; addra = 10'h020; dina = 16'h1111;
        enb = 1'b1; web = 1'b1; addrb = 10'h020; dinb = 16'h2222;
        tick();
        idle();
        read_b(10'h020, "dual_write_b", 16'h1111);
        read_a(10'h020, "dual_write_a", 16'h1111);

        // Both ports write different rows: both land.
        ena = 1'b1; wea = 1'b1; addra = 10'h040; dina = 16'h0AAA;
        enb = 1'b1; web = 1'b1; addrb = 10'h041; dinb = 16'h0BBB;
        tick();
        idle();
        read_a(10'h041, "indep_b_write", 16'h0BBB);
        read_b(10'h040, "indep_a_write", 16'h0AAA);
        read_b(10'h3FF, "top_row_zero", 16'h0000);

        // Read-modify-write stream on 0x030: A writes k at edge k while B
        // reads every edge; doutb trails the stored value by the latency.
        idle();
        for (int k = 1; k <= 3; k++) begin
            ena = 1'b1; wea = 1'b1; addra = 10'h030; dina = 16'(k);
            enb = 1'b1; addrb = 10'h030;
            tick();
            if (k >= LAT) check($sformatf("rmw_step%0d", k), doutb, 16'(k - LAT));
        end
        read_b(10'h030, "rmw_final", 16'h0003);

        // enb=0 holds doutb across address changes.
        read_b(10'h00A, "hold_setup", 16'h0123);
        enb = 1'b0; addrb = 10'h010;
        tick();
        check("hold_addr_010", doutb, 16'h0123);
        addrb = 10'h020;
        tick();
        check("hold_addr_020", doutb, 16'h0123);

        // Reset mid-stream with a write attempt: outputs clear, memory kept.
        reset = 1'b1;
        ena = 1'b1; wea = 1'b1; addra = 10'h00A; dina = 16'hFFFF;
        enb = 1'b1; addrb = 10'h00A;
        tick();
        check("midreset_doutb", doutb, 16'h0000);
        check("midreset_douta", douta, 16'h0000);
        reset = 1'b0;
        idle();
        read_b(10'h00A, "after_reset_mem", 16'h0123);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
